// File: rtl/pipeline_f.sv
// Instruction-fetch stage: PC register, combinational instruction ROM and the
// F/D pipeline register feeding decode. Redirects never flush F/D (delay slot).
module pipeline_f #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_AW    = 10,
  parameter string       IM_FILE  = "code.txt"
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        PCSel,
  input  logic [31:0] NPCOut,
  output logic [31:0] Instr_D,
  output logic [31:0] PCPlus4_D,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_F
);

  localparam logic [31:0] IM_BYTES = 32'(4) << IM_AW;

  logic [31:0]      im [0:(1 << IM_AW) - 1];
  logic [31:0]      offset;
  logic [31:0]      pc_plus4;
  logic [IM_AW-1:0] im_idx;
  logic             in_range;

  // Offset is taken relative to PC_RESET; anything below it or past the ROM
  // end reads as a nop instead of aliasing into the image.
  always_comb begin
    pc_plus4 = PC_F + 32'd4;
    offset   = PC_F - PC_RESET;
    im_idx   = IM_AW'(offset >> 2);
    in_range = (PC_F >= PC_RESET) && (offset < IM_BYTES);
    Instr_F  = in_range ? im[im_idx] : '0;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      PC_F      <= PC_RESET;
      Instr_D   <= '0;
      PCPlus4_D <= '0;
    end else if (!Stall) begin
      PC_F      <= PCSel ? NPCOut : pc_plus4;
      Instr_D   <= Instr_F;
      PCPlus4_D <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pipeline_f.sv
// Bench for pipeline_f: directed vector table for the fetch/redirect/stall/
// range/wrap cases, async reset check, then randomized run against a model.
module tb_pipeline_f;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        PCSel;
  logic [31:0] NPCOut;
  logic [31:0] Instr_D, PCPlus4_D, PC_F, Instr_F;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [31:0] rom [0:1023];

  pipeline_f #(
    .PC_RESET(32'h0000_3000),
    .IM_AW   (10)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Stall    (Stall),
    .PCSel    (PCSel),
    .NPCOut   (NPCOut),
    .Instr_D  (Instr_D),
    .PCPlus4_D(PCPlus4_D),
    .PC_F     (PC_F),
    .Instr_F  (Instr_F)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall;
    logic        sel;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] instr_f;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ROM lookup from the address rules: byte window [0x3000, 0x4000).
  function automatic logic [31:0] fetch(input logic [31:0] pc);
    longint unsigned a;
    a = longint'(pc);
    if (a >= 64'h3000 && a < 64'h3000 + 64'd4096)
      return rom[int'((a - 64'h3000) / 4)];
    return 32'h0;
  endfunction

  logic [31:0] m_pc, m_id, m_p4;
  logic        r_st, r_sel;
  logic [31:0] r_npc;

  initial begin
    Reset  = 1'b1;
    Stall  = 1'b0;
    PCSel  = 1'b0;
    NPCOut = '0;
    #1;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h3c01_1234;
    rom[1] = 32'h3421_5678;
    for (int i = 0; i < 1024; i++) dut.im[i] = rom[i];

    // Reset held across edges
    @(posedge CLK); @(posedge CLK); #1;
    check("reset_pc", PC_F, 32'h3000);
    check("reset_instr_d", Instr_D, 32'h0);
    check("reset_pc4_d", PCPlus4_D, 32'h0);
    check("reset_instr_f", Instr_F, 32'h3c01_1234);
    Reset = 1'b0;

    //            stall sel  npc           pc            instr_f   instr_d       pc4_d
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h3004,     rom[1],   32'h3c011234, 32'h3004});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h3008,     rom[2],   32'h34215678, 32'h3008});
    vecs.push_back('{1'b0, 1'b1, 32'h3040,     32'h3040,     rom[16],  rom[2],       32'h300c});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h3044,     rom[17],  rom[16],      32'h3044});
    vecs.push_back('{1'b1, 1'b1, 32'h3100,     32'h3044,     rom[17],  rom[16],      32'h3044});
    vecs.push_back('{1'b1, 1'b1, 32'h3100,     32'h3044,     rom[17],  rom[16],      32'h3044});
    vecs.push_back('{1'b1, 1'b1, 32'h3100,     32'h3044,     rom[17],  rom[16],      32'h3044});
    vecs.push_back('{1'b0, 1'b1, 32'h3100,     32'h3100,     rom[64],  rom[17],      32'h3048});
    vecs.push_back('{1'b0, 1'b1, 32'h2ffc,     32'h2ffc,     32'h0,    rom[64],      32'h3104});
    vecs.push_back('{1'b0, 1'b1, 32'h7000,     32'h7000,     32'h0,    32'h0,        32'h3000});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h7004,     32'h0,    32'h0,        32'h7004});
    vecs.push_back('{1'b0, 1'b1, 32'hfffffffc, 32'hfffffffc, 32'h0,    32'h0,        32'h7008});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        32'h0,    32'h0,        32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h4,        32'h0,    32'h0,        32'h4});
    vecs.push_back('{1'b0, 1'b1, 32'h3020,     32'h3020,     rom[8],   32'h0,        32'h8});

    foreach (vecs[k]) begin
      Stall  = vecs[k].stall;
      PCSel  = vecs[k].sel;
      NPCOut = vecs[k].npc;
      @(posedge CLK); #1;
      check($sformatf("vec%0d_pc", k), PC_F, vecs[k].pc);
      check($sformatf("vec%0d_instr_f", k), Instr_F, vecs[k].instr_f);
      check($sformatf("vec%0d_instr_d", k), Instr_D, vecs[k].instr_d);
      check($sformatf("vec%0d_pc4_d", k), PCPlus4_D, vecs[k].pc4_d);
    end

    // Async reset between edges, while a stall and redirect are pending
    Stall  = 1'b1;
    PCSel  = 1'b1;
    NPCOut = 32'h3200;
    #2;
    Reset = 1'b1;
    #1;
    check("async_pc", PC_F, 32'h3000);
    check("async_instr_d", Instr_D, 32'h0);
    check("async_pc4_d", PCPlus4_D, 32'h0);
    @(posedge CLK); #1;
    check("async_hold_pc", PC_F, 32'h3000);
    Reset = 1'b0;
    Stall = 1'b0;
    PCSel = 1'b0;

    // Randomized run against the model
    m_pc = 32'h3000;
    m_id = 32'h0;
    m_p4 = 32'h0;
    for (int c = 0; c < 600; c++) begin
      r_st  = ($urandom_range(0, 3) == 0);
      r_sel = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       r_npc = $urandom;
        1:       r_npc = 32'h3000 - 4 * $urandom_range(1, 4);
        2:       r_npc = 32'h4000 + 4 * $urandom_range(0, 4);
        3:       r_npc = 32'h3ffc;
        default: r_npc = 32'h3000 + 4 * $urandom_range(0, 1023);
      endcase
      Stall  = r_st;
      PCSel  = r_sel;
      NPCOut = r_npc;
      @(posedge CLK);
      if (!r_st) begin
        m_id = fetch(m_pc);
        m_p4 = m_pc + 32'd4;
        m_pc = r_sel ? r_npc : m_pc + 32'd4;
      end
      #1;
      check("rnd_pc", PC_F, m_pc);
      check("rnd_instr_f", Instr_F, fetch(m_pc));
      check("rnd_instr_d", Instr_D, m_id);
      check("rnd_pc4_d", PCPlus4_D, m_p4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
